// File: rtl/mp64_kem_dma_pkg.sv
// mp64_kem_dma_pkg: shared constants for the KEM byte-streaming DMA engine.
// KEM slave register offsets, buffer IDs/sizes, status codes, DMA register
// offsets and the engine state encoding.
// Optional feature macro: MP64_KEM_DMA_AUTOCMD_EN adds the CMD/POLL states.
package mp64_kem_dma_pkg;

  // KEM slave register offsets
  localparam logic [5:0] KEM_REG_CMD     = 6'h00;  // write: command, read: status
  localparam logic [5:0] KEM_REG_BUF_SEL = 6'h08;
  localparam logic [5:0] KEM_REG_DATA    = 6'h10;
  localparam logic [5:0] KEM_REG_IDX     = 6'h18;

  // KEM buffer IDs and their sizes in bytes
  localparam logic [2:0] KEM_BUF_SEED = 3'd0;
  localparam logic [2:0] KEM_BUF_PK   = 3'd1;
  localparam logic [2:0] KEM_BUF_SK   = 3'd2;
  localparam logic [2:0] KEM_BUF_CT   = 3'd3;
  localparam logic [2:0] KEM_BUF_SS   = 3'd4;

  localparam logic [11:0] KEM_SIZE_SEED = 12'd64;
  localparam logic [11:0] KEM_SIZE_PK   = 12'd800;
  localparam logic [11:0] KEM_SIZE_SK   = 12'd1632;
  localparam logic [11:0] KEM_SIZE_CT   = 12'd768;
  localparam logic [11:0] KEM_SIZE_SS   = 12'd32;

  // KEM status codes
  localparam logic [7:0] KEM_STATUS_IDLE = 8'd0;
  localparam logic [7:0] KEM_STATUS_DONE = 8'd2;

  // DMA slave register offsets
  localparam logic [5:0] DMA_REG_CTRL     = 6'h00;
  localparam logic [5:0] DMA_REG_MEM_ADDR = 6'h08;
  localparam logic [5:0] DMA_REG_LEN      = 6'h10;
  localparam logic [5:0] DMA_REG_KIDX     = 6'h18;
  localparam logic [5:0] DMA_REG_COUNT    = 6'h20;

  // Status reads allowed before declaring the KEM stuck
  localparam logic [15:0] POLL_LIMIT = 16'hFFFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEL,
    ST_IDX,
    ST_MRD,
    ST_KWR,
    ST_KRD,
    ST_MWR,
`ifdef MP64_KEM_DMA_AUTOCMD_EN
    ST_CMD,
    ST_POLL,
`endif
    ST_FIN
  } dma_state_t;

  // Size of a KEM buffer; unknown IDs report 0 so any non-empty request fails
  function automatic logic [11:0] kem_buf_size(input logic [2:0] id);
    case (id)
      KEM_BUF_SEED: kem_buf_size = KEM_SIZE_SEED;
      KEM_BUF_PK:   kem_buf_size = KEM_SIZE_PK;
      KEM_BUF_SK:   kem_buf_size = KEM_SIZE_SK;
      KEM_BUF_CT:   kem_buf_size = KEM_SIZE_CT;
      KEM_BUF_SS:   kem_buf_size = KEM_SIZE_SS;
      default:      kem_buf_size = 12'd0;
    endcase
  endfunction

endpackage

// File: rtl/mp64_kem_dma_pack.sv
// mp64_kem_dma_pack: 8-lane byte packer/unpacker. Holds one 64-bit memory
// word, the current byte lane and the mask of lanes filled from the KEM side.
module mp64_kem_dma_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,      // empty the word, lane back to 0
  input  logic        load,       // take a whole word from memory
  input  logic [63:0] load_data,
  input  logic        adv,        // current lane consumed
  input  logic        put,        // write put_byte into current lane
  input  logic [7:0]  put_byte,
  output logic [63:0] word,
  output logic [2:0]  lane,
  output logic [7:0]  cur_byte,
  output logic [7:0]  be
);

  logic [2:0] lane_reg;

  // Lane pointer: restarts on every new word, steps on each byte moved
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_reg <= 3'd0;
    end else if (clear || load) begin
      lane_reg <= 3'd0;
    end else if (adv || put) begin
      lane_reg <= lane_reg + 3'd1;
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    logic [7:0] byte_reg;
    logic       be_reg;

    // Per-lane byte storage and fill flag
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        byte_reg <= 8'd0;
        be_reg   <= 1'b0;
      end else if (clear) begin
        byte_reg <= 8'd0;
        be_reg   <= 1'b0;
      end else if (load) begin
        byte_reg <= load_data[gi*8 +: 8];
        be_reg   <= 1'b0;
      end else if (put && (lane_reg == 3'(gi))) begin
        byte_reg <= put_byte;
        be_reg   <= 1'b1;
      end
    end

    assign word[gi*8 +: 8] = byte_reg;
    assign be[gi]          = be_reg;
  end

  assign lane     = lane_reg;
  assign cur_byte = word[{lane_reg, 3'b000} +: 8];

endmodule

// File: rtl/mp64_kem_dma.sv
// mp64_kem_dma: byte-streaming DMA between 64-bit system memory and one KEM
// buffer through the KEM MMIO byte port. CPU programs it via a small slave.
// Optional feature macro: MP64_KEM_DMA_AUTOCMD_EN (issue a KEM command and
// poll for completion after a mem->kem load).
module mp64_kem_dma
  import mp64_kem_dma_pkg::*;
#(
  parameter int MEM_AW = 32,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_req,
  input  logic [5:0]        s_addr,
  input  logic [63:0]       s_wdata,
  input  logic              s_wen,
  output logic [63:0]       s_rdata,
  output logic              s_ack,
  output logic              k_req,
  output logic [5:0]        k_addr,
  output logic [63:0]       k_wdata,
  output logic              k_wen,
  input  logic [63:0]       k_rdata,
  input  logic              k_ack,
  output logic              m_req,
  output logic [MEM_AW-1:0] m_addr,
  output logic [63:0]       m_wdata,
  output logic [7:0]        m_be,
  output logic              m_wen,
  input  logic [63:0]       m_rdata,
  input  logic              m_ack,
  output logic              irq
);

  dma_state_t        state_reg, state_next;
  logic [MEM_AW-1:0] mem_addr_reg, ptr_reg;
  logic [LEN_W-1:0]  len_reg, kidx_reg, count_reg;
  logic [2:0]        buf_id_reg;
  logic              dir_reg, irq_en_reg, done_reg, err_reg, gap_reg;
  logic [63:0]       rd_data;
  logic [63:0]       pk_word;
  logic [2:0]        pk_lane;
  logic [7:0]        pk_cur_byte, pk_be;

  logic busy, s_wr, ctrl_wr, start_req, start_valid;
  logic k_done, m_done, last_byte, lane_last;
  logic unused_bits;

  assign busy        = (state_reg != ST_IDLE);
  assign s_wr        = s_req & s_wen;
  assign ctrl_wr     = s_wr && (s_addr == DMA_REG_CTRL);
  assign start_req   = ctrl_wr && s_wdata[0] && !busy;
  assign start_valid = (s_wdata[4:2] <= KEM_BUF_SS) && (len_reg != '0) &&
                       ((32'(kidx_reg) + 32'(len_reg)) <= 32'(kem_buf_size(s_wdata[4:2])));
  assign k_done      = k_req & k_ack;
  assign m_done      = m_req & m_ack;
  assign last_byte   = ((count_reg + LEN_W'(1)) == len_reg);
  assign lane_last   = (pk_lane == 3'd7);
  assign irq         = irq_en_reg & (done_reg | err_reg);
  assign unused_bits = ^{s_wdata[63:MEM_AW], k_rdata[63:8]};

`ifdef MP64_KEM_DMA_AUTOCMD_EN
  logic [2:0]  autocmd_reg;
  logic [15:0] poll_cnt_reg;
  logic        cmd_en, poll_ok, poll_timeout;

  assign cmd_en       = (autocmd_reg != 3'd0) && (autocmd_reg <= 3'd3);
  assign poll_ok      = (k_rdata[7:0] == KEM_STATUS_DONE);
  assign poll_timeout = (state_reg == ST_POLL) && k_done && !poll_ok &&
                        (poll_cnt_reg == POLL_LIMIT - 16'd1);

  // Autocommand code capture and unsuccessful-poll counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      autocmd_reg  <= 3'd0;
      poll_cnt_reg <= 16'd0;
    end else begin
      if (start_req && start_valid) autocmd_reg <= s_wdata[9:7];
      if (state_reg == ST_CMD) poll_cnt_reg <= 16'd0;
      else if (state_reg == ST_POLL && k_done) poll_cnt_reg <= poll_cnt_reg + 16'd1;
    end
  end
`endif

  mp64_kem_dma_pack u_pack (
    .clk       (clk),
    .rst       (rst),
    .clear     ((start_req && start_valid) || (state_reg == ST_MWR && m_done)),
    .load      (state_reg == ST_MRD && m_done),
    .load_data (m_rdata),
    .adv       (state_reg == ST_KWR && k_done),
    .put       (state_reg == ST_KRD && k_done),
    .put_byte  (k_rdata[7:0]),
    .word      (pk_word),
    .lane      (pk_lane),
    .cur_byte  (pk_cur_byte),
    .be        (pk_be)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state: each bus state advances only on its own ack
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start_req && start_valid) state_next = ST_SEL;
      ST_SEL:  if (k_done) state_next = ST_IDX;
      ST_IDX:  if (k_done) state_next = dir_reg ? ST_KRD : ST_MRD;
      ST_MRD:  if (m_done) state_next = ST_KWR;
      ST_KWR: begin
        if (k_done) begin
          if (last_byte) begin
`ifdef MP64_KEM_DMA_AUTOCMD_EN
            state_next = cmd_en ? ST_CMD : ST_FIN;
`else
            state_next = ST_FIN;
`endif
          end else if (lane_last) begin
            state_next = ST_MRD;
          end
        end
      end
      ST_KRD:  if (k_done && (last_byte || lane_last)) state_next = ST_MWR;
      ST_MWR:  if (m_done) state_next = (count_reg == len_reg) ? ST_FIN : ST_KRD;
`ifdef MP64_KEM_DMA_AUTOCMD_EN
      ST_CMD:  if (k_done) state_next = ST_POLL;
      ST_POLL: begin
        if (k_done) begin
          if (poll_ok)           state_next = ST_FIN;
          else if (poll_timeout) state_next = ST_IDLE;
        end
      end
`endif
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus outputs decoded from state; req is withheld for one cycle after any ack
  always_comb begin
    k_req   = 1'b0;
    k_addr  = 6'd0;
    k_wdata = 64'd0;
    k_wen   = 1'b0;
    m_req   = 1'b0;
    m_addr  = '0;
    m_wdata = 64'd0;
    m_be    = 8'd0;
    m_wen   = 1'b0;
    case (state_reg)
      ST_SEL: begin
        k_req = !gap_reg; k_addr = KEM_REG_BUF_SEL; k_wdata = 64'(buf_id_reg); k_wen = 1'b1;
      end
      ST_IDX: begin
        k_req = !gap_reg; k_addr = KEM_REG_IDX; k_wdata = 64'(kidx_reg); k_wen = 1'b1;
      end
      ST_KWR: begin
        k_req = !gap_reg; k_addr = KEM_REG_DATA; k_wdata = 64'(pk_cur_byte); k_wen = 1'b1;
      end
      ST_KRD: begin
        k_req = !gap_reg; k_addr = KEM_REG_DATA;
      end
      ST_MRD: begin
        m_req = !gap_reg; m_addr = ptr_reg;
      end
      ST_MWR: begin
        m_req = !gap_reg; m_addr = ptr_reg; m_wdata = pk_word; m_be = pk_be; m_wen = 1'b1;
      end
`ifdef MP64_KEM_DMA_AUTOCMD_EN
      ST_CMD: begin
        k_req = !gap_reg; k_addr = KEM_REG_CMD; k_wdata = 64'(autocmd_reg); k_wen = 1'b1;
      end
      ST_POLL: begin
        k_req = !gap_reg; k_addr = KEM_REG_CMD;
      end
`endif
      default: ;
    endcase
  end

  // Programming registers, transfer pointer/count and sticky DONE/ERR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_reg <= '0;
      ptr_reg      <= '0;
      len_reg      <= '0;
      kidx_reg     <= '0;
      count_reg    <= '0;
      buf_id_reg   <= 3'd0;
      dir_reg      <= 1'b0;
      irq_en_reg   <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      gap_reg      <= 1'b0;
    end else begin
      gap_reg <= k_done | m_done;
      if (s_wr && !busy) begin
        case (s_addr)
          DMA_REG_MEM_ADDR: mem_addr_reg <= {s_wdata[MEM_AW-1:3], 3'b000};
          DMA_REG_LEN:      len_reg      <= s_wdata[LEN_W-1:0];
          DMA_REG_KIDX:     kidx_reg     <= s_wdata[LEN_W-1:0];
          default: ;
        endcase
      end
      if (state_reg == ST_FIN) done_reg <= 1'b1;
      if (ctrl_wr) begin
        irq_en_reg <= s_wdata[5];
        if (s_wdata[6]) begin
          done_reg <= 1'b0;
          err_reg  <= 1'b0;
        end
      end
      if (start_req) begin
        if (start_valid) begin
          dir_reg    <= s_wdata[1];
          buf_id_reg <= s_wdata[4:2];
          ptr_reg    <= mem_addr_reg;
          count_reg  <= '0;
          done_reg   <= 1'b0;
          err_reg    <= 1'b0;
        end else begin
          err_reg <= 1'b1;
        end
      end
      if (m_done) ptr_reg <= ptr_reg + MEM_AW'(8);
      if ((state_reg == ST_KWR || state_reg == ST_KRD) && k_done) count_reg <= count_reg + LEN_W'(1);
`ifdef MP64_KEM_DMA_AUTOCMD_EN
      if (poll_timeout) err_reg <= 1'b1;
`endif
    end
  end

  // Slave read mux
  always_comb begin
    rd_data = 64'd0;
    case (s_addr)
      DMA_REG_CTRL: begin
        rd_data[2:0] = {err_reg, done_reg, busy};
`ifdef MP64_KEM_DMA_AUTOCMD_EN
        rd_data[9:7] = autocmd_reg;
`endif
      end
      DMA_REG_MEM_ADDR: rd_data[MEM_AW-1:0] = mem_addr_reg;
      DMA_REG_LEN:      rd_data[LEN_W-1:0]  = len_reg;
      DMA_REG_KIDX:     rd_data[LEN_W-1:0]  = kidx_reg;
      DMA_REG_COUNT:    rd_data[LEN_W-1:0]  = count_reg;
      default: ;
    endcase
  end

  // Slave response: ack and read data one cycle after the request, never stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack   <= 1'b0;
      s_rdata <= 64'd0;
    end else begin
      s_ack <= s_req;
      if (s_req && !s_wen) s_rdata <= rd_data;
    end
  end

endmodule

// File: tb/tb_mp64_kem_dma.sv
// tb_mp64_kem_dma: directed bench for mp64_kem_dma with simple KEM and memory
// responder models. Define MP64_KEM_DMA_AUTOCMD_EN to also run the autocommand step.
module tb_mp64_kem_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_req = 1'b0;
  logic [5:0]  s_addr = 6'd0;
  logic [63:0] s_wdata = 64'd0;
  logic        s_wen = 1'b0;
  logic [63:0] s_rdata;
  logic        s_ack;
  logic        k_req;
  logic [5:0]  k_addr;
  logic [63:0] k_wdata;
  logic        k_wen;
  logic [63:0] k_rdata;
  logic        k_ack;
  logic        m_req;
  logic [31:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_be;
  logic        m_wen;
  logic [63:0] m_rdata;
  logic        m_ack;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  // Responder model state
  logic [7:0]  kbuf [0:4][0:2047];
  logic [7:0]  mem  [0:255];
  logic [2:0]  ksel;
  logic [10:0] kidx;
  logic [7:0]  kstat = 8'd0;
  logic [7:0]  kcmd = 8'd0;
  int          kpoll_left = 0;
  int          k_wr_n = 0, k_rd_n = 0, k_din_n = 0, m_rd_n = 0, m_wr_n = 0;
  logic [7:0]  last_be = 8'd0;

  always #5 clk = ~clk;

  mp64_kem_dma dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_wen(s_wen),
    .s_rdata(s_rdata), .s_ack(s_ack),
    .k_req(k_req), .k_addr(k_addr), .k_wdata(k_wdata), .k_wen(k_wen),
    .k_rdata(k_rdata), .k_ack(k_ack),
    .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be), .m_wen(m_wen),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .irq(irq)
  );

  // KEM slave model: ack one cycle after req
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k_ack   <= 1'b0;
      k_rdata <= 64'd0;
    end else begin
      k_ack <= 1'b0;
      if (k_req && !k_ack) begin
        k_ack <= 1'b1;
        if (k_wen) begin
          k_wr_n <= k_wr_n + 1;
          case (k_addr)
            6'h00: begin kcmd <= k_wdata[7:0]; kstat <= 8'd1; kpoll_left <= 3; end
            6'h08: ksel <= k_wdata[2:0];
            6'h18: kidx <= k_wdata[10:0];
            6'h10: begin
              kbuf[ksel][kidx] <= k_wdata[7:0];
              kidx    <= kidx + 11'd1;
              k_din_n <= k_din_n + 1;
            end
            default: ;
          endcase
        end else begin
          k_rd_n <= k_rd_n + 1;
          case (k_addr)
            6'h00: begin
              k_rdata <= {56'd0, kstat};
              if (kstat == 8'd1) begin
                if (kpoll_left == 0) begin
                  kstat      <= 8'd2;
                  kbuf[1][0] <= 8'h5A;
                end else begin
                  kpoll_left <= kpoll_left - 1;
                end
              end
            end
            6'h10: begin
              k_rdata <= {56'd0, kbuf[ksel][kidx]};
              kidx    <= kidx + 11'd1;
            end
            default: k_rdata <= 64'd0;
          endcase
        end
      end
    end
  end

  // Memory model: 256 bytes, ack one cycle after req
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ack   <= 1'b0;
      m_rdata <= 64'd0;
    end else begin
      m_ack <= 1'b0;
      if (m_req && !m_ack) begin
        m_ack <= 1'b1;
        if (m_wen) begin
          for (int i = 0; i < 8; i++)
            if (m_be[i]) mem[8'(m_addr[7:0] + 8'(i))] <= m_wdata[i*8 +: 8];
          last_be <= m_be;
          m_wr_n  <= m_wr_n + 1;
        end else begin
          for (int i = 0; i < 8; i++)
            m_rdata[i*8 +: 8] <= mem[8'(m_addr[7:0] + 8'(i))];
          m_rd_n <= m_rd_n + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [63:0] d);
    @(negedge clk);
    s_req = 1'b1; s_wen = 1'b1; s_addr = a; s_wdata = d;
    @(posedge clk);
    #1;
    s_req = 1'b0; s_wen = 1'b0;
  endtask

  task automatic cpu_read(input logic [5:0] a, output logic [63:0] d);
    @(negedge clk);
    s_req = 1'b1; s_wen = 1'b0; s_addr = a;
    @(posedge clk);
    #1;
    s_req = 1'b0;
    d = s_rdata;
  endtask

  task automatic wait_idle(input string tag);
    logic [63:0] st;
    st = 64'd1;
    for (int i = 0; i < 1500; i++) begin
      cpu_read(6'h00, st);
      if (!st[0]) break;
    end
    check(tag, {63'd0, st[0]}, 64'd0);
  endtask

  initial begin
    logic [63:0] rd;
    int base_kw, base_kr, base_mr, base_mw, base_din;
    logic found;

    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    for (int b = 0; b < 5; b++)
      for (int i = 0; i < 64; i++) kbuf[b][i] = 8'd0;

    // ---- reset state
    repeat (2) @(negedge clk);
    check("rst_s_ack", {63'd0, s_ack}, 64'd0);
    check("rst_k_req", {63'd0, k_req}, 64'd0);
    check("rst_m_req", {63'd0, m_req}, 64'd0);
    rst = 1'b0;
    cpu_read(6'h00, rd);
    check("rst_status", rd, 64'd0);
    cpu_read(6'h20, rd);
    check("rst_count", rd, 64'd0);
    check("rst_irq", {63'd0, irq}, 64'd0);

    // ---- mem->kem, BUF 0, KIDX 0, LEN 16
    for (int i = 0; i < 16; i++) mem[8'h40 + i] = 8'(i) ^ 8'hAA;
    cpu_write(6'h08, 64'h45);
    cpu_read(6'h08, rd);
    check("memaddr_align", rd, 64'h40);
    cpu_write(6'h10, 64'd16);
    cpu_write(6'h18, 64'd0);
    base_kw = k_wr_n; base_mr = m_rd_n;
    cpu_write(6'h00, 64'h01);
    check("start_s_ack", {63'd0, s_ack}, 64'd1);
    check("start_k_req", {63'd0, k_req}, 64'd1);
    check("start_k_addr", {58'd0, k_addr}, 64'h08);
    wait_idle("t1_idle");
    check("t1_kwrites", 64'(k_wr_n - base_kw), 64'd18);
    check("t1_mreads", 64'(m_rd_n - base_mr), 64'd2);
    check("t1_kbuf0", {56'd0, kbuf[0][0]}, 64'hAA);
    check("t1_kbuf1", {56'd0, kbuf[0][1]}, 64'hAB);
    check("t1_kbuf15", {56'd0, kbuf[0][15]}, 64'hA5);
    cpu_read(6'h00, rd);
    check("t1_status", rd, 64'h2);
    cpu_read(6'h20, rd);
    check("t1_count", rd, 64'd16);

    // ---- kem->mem, BUF 4, LEN 13, IRQ_EN
    for (int i = 0; i < 13; i++) kbuf[4][i] = 8'(i + 1);
    for (int i = 0; i < 16; i++) mem[8'h80 + i] = 8'hEE;
    cpu_write(6'h00, 64'h40);
    cpu_read(6'h00, rd);
    check("t2_cleared", rd, 64'h0);
    cpu_write(6'h08, 64'h80);
    cpu_write(6'h10, 64'd13);
    base_mw = m_wr_n;
    cpu_write(6'h00, 64'h33);
    wait_idle("t2_idle");
    check("t2_mwrites", 64'(m_wr_n - base_mw), 64'd2);
    check("t2_last_be", {56'd0, last_be}, 64'h1F);
    check("t2_mem0", {56'd0, mem[8'h80]}, 64'h01);
    check("t2_mem12", {56'd0, mem[8'h8C]}, 64'h0D);
    check("t2_mem13_kept", {56'd0, mem[8'h8D]}, 64'hEE);
    check("t2_irq", {63'd0, irq}, 64'd1);
    cpu_read(6'h20, rd);
    check("t2_count", rd, 64'd13);

    // ---- START validation errors
    cpu_write(6'h00, 64'h40);
    check("t3_irq_clr", {63'd0, irq}, 64'd0);
    base_kw = k_wr_n; base_kr = k_rd_n; base_mr = m_rd_n; base_mw = m_wr_n;
    cpu_write(6'h00, 64'h15);                 // BUF_ID 5
    repeat (3) @(negedge clk);
    cpu_read(6'h00, rd);
    check("t3_buf5_err", rd, 64'h4);
    cpu_write(6'h00, 64'h40);
    cpu_write(6'h10, 64'd0);
    cpu_write(6'h00, 64'h01);                 // LEN 0
    repeat (3) @(negedge clk);
    cpu_read(6'h00, rd);
    check("t3_len0_err", rd, 64'h4);
    cpu_write(6'h00, 64'h40);
    cpu_write(6'h10, 64'd4);
    cpu_write(6'h18, 64'd30);
    cpu_write(6'h00, 64'h11);                 // BUF 4, 30+4 > 32
    repeat (3) @(negedge clk);
    cpu_read(6'h00, rd);
    check("t3_ovf_err", rd, 64'h4);
    check("t3_no_ktraffic", 64'((k_wr_n - base_kw) + (k_rd_n - base_kr)), 64'd0);
    check("t3_no_mtraffic", 64'((m_rd_n - base_mr) + (m_wr_n - base_mw)), 64'd0);
    cpu_write(6'h00, 64'h40);
    cpu_write(6'h18, 64'd28);
    cpu_write(6'h00, 64'h11);                 // BUF 4, 28+4 == 32 exactly
    wait_idle("t3_edge_idle");
    cpu_read(6'h00, rd);
    check("t3_edge_done", rd, 64'h2);
    check("t3_edge_kbuf31", {56'd0, kbuf[4][31]}, 64'h04);

    // ---- slave writes while BUSY
    for (int i = 0; i < 64; i++) mem[i] = 8'(i + 8'h10);
    cpu_write(6'h08, 64'h0);
    cpu_write(6'h10, 64'd64);
    cpu_write(6'h18, 64'd0);
    base_din = k_din_n;
    cpu_write(6'h00, 64'h41);
    cpu_write(6'h10, 64'd5);
    cpu_write(6'h00, 64'h05);
    cpu_read(6'h10, rd);
    check("t5_len_kept", rd, 64'd64);
    cpu_read(6'h00, rd);
    check("t5_busy", rd, 64'h1);
    wait_idle("t5_idle");
    cpu_read(6'h20, rd);
    check("t5_count", rd, 64'd64);
    check("t5_din", 64'(k_din_n - base_din), 64'd64);
    check("t5_kbuf63", {56'd0, kbuf[0][63]}, 64'h4F);

    // ---- reset mid-transfer
    cpu_write(6'h00, 64'h40);
    base_din = k_din_n;
    cpu_write(6'h00, 64'h01);
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (k_req && k_wen && k_addr == 6'h10 && (k_din_n - base_din) >= 5) begin
        found = 1'b1;
        break;
      end
    end
    check("t4_reached_kwr", {63'd0, found}, 64'd1);
    rst = 1'b1;
    #1;
    check("t4_k_req", {63'd0, k_req}, 64'd0);
    check("t4_k_wen", {63'd0, k_wen}, 64'd0);
    check("t4_k_addr", {58'd0, k_addr}, 64'd0);
    check("t4_m_req", {63'd0, m_req}, 64'd0);
    check("t4_s_ack", {63'd0, s_ack}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cpu_read(6'h00, rd);
    check("t4_status", rd, 64'h0);
    cpu_read(6'h10, rd);
    check("t4_len_reset", rd, 64'h0);
    cpu_write(6'h08, 64'h0);
    cpu_write(6'h10, 64'd8);
    cpu_write(6'h18, 64'd8);
    cpu_write(6'h00, 64'h01);
    wait_idle("t4_rerun_idle");
    cpu_read(6'h00, rd);
    check("t4_rerun_done", rd, 64'h2);
    cpu_read(6'h20, rd);
    check("t4_rerun_count", rd, 64'd8);
    check("t4_kbuf8", {56'd0, kbuf[0][8]}, 64'h10);
    check("t4_kbuf15", {56'd0, kbuf[0][15]}, 64'h17);

`ifdef MP64_KEM_DMA_AUTOCMD_EN
    // ---- autocommand keygen after seed load
    for (int i = 0; i < 8; i++) kbuf[1][i] = 8'd0;
    cpu_write(6'h08, 64'h0);
    cpu_write(6'h10, 64'd64);
    cpu_write(6'h18, 64'd0);
    cpu_write(6'h00, 64'hC1);
    wait_idle("t6_idle");
    check("t6_cmd", {56'd0, kcmd}, 64'd1);
    check("t6_kstat", {56'd0, kstat}, 64'd2);
    cpu_read(6'h00, rd);
    check("t6_done", {61'd0, rd[2:0]}, 64'h2);
    cpu_write(6'h08, 64'hC0);
    cpu_write(6'h10, 64'd8);
    cpu_write(6'h18, 64'd0);
    cpu_write(6'h00, 64'h47);
    wait_idle("t6_pk_idle");
    check("t6_pk0", {56'd0, mem[8'hC0]}, 64'h5A);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mp64_kem_dma.md
Name: mp64_kem_dma

Overview:
- Byte-streaming DMA engine directly upstream/downstream of mp64_kem.
- Moves data between system memory (64-bit word port) and one KEM buffer through the KEM MMIO byte port (BUF_SEL 0x08, DIN/DOUT 0x10, IDX_SET 0x18).
- The CPU no longer issues one MMIO write per seed/pk/ct byte. The CPU programs the engine via its own small MMIO slave; the engine acts as the sole bus master on the KEM slave port.

Parameters:
- MEM_AW, 32, memory byte-address width.
- LEN_W, 11, width of the length/index/count fields (max 1632 fits).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-high
- s_req  in  1  CPU slave request
- s_addr  in  6  CPU slave register address
- s_wdata  in  64  CPU slave write data
- s_wen  in  1  CPU slave write enable
- s_rdata  out  64  CPU slave read data, registered
- s_ack  out  1  CPU slave ack, one cycle after s_req
- k_req  out  1  KEM master request
- k_addr  out  6  KEM master address
- k_wdata  out  64  KEM master write data
- k_wen  out  1  KEM master write enable
- k_rdata  in  64  KEM read data, valid with k_ack
- k_ack  in  1  KEM ack
- m_req  out  1  memory request
- m_addr  out  MEM_AW  memory byte address, 8-aligned
- m_wdata  out  64  memory write data, little-endian byte lanes
- m_be  out  8  memory byte enables, writes only
- m_wen  out  1  memory write enable
- m_rdata  in  64  memory read data, valid with m_ack
- m_ack  in  1  memory ack
- irq  out  1  level; high while DONE or ERR is set and IRQ_EN=1

Behaviour:
- Reset: all outputs 0; registers 0; state IDLE.
- Reset mid-transfer: abort immediately; k_req and m_req drop with reset.
- Slave register map:
  - 0x00 CTRL write: bit0 START, bit1 DIR (0 = mem->kem, 1 = kem->mem), [4:2] BUF_ID, bit5 IRQ_EN, bit6 W1C clear DONE/ERR.
  - 0x00 read: bit0 BUSY, bit1 DONE, bit2 ERR.
  - 0x08 MEM_ADDR: bits [2:0] forced 0.
  - 0x10 LEN: bytes.
  - 0x18 KIDX: starting buffer index.
  - 0x20 COUNT (RO): bytes moved so far.
- Register writes other than CTRL while BUSY are ignored.
- Master handshake (k_* and m_*): hold req/addr/wdata/wen stable until ack; drop req the cycle after ack. Never more than one request outstanding per port.
- START validation:
  - ERR=1, no bus traffic, if BUF_ID > 4, LEN == 0, or KIDX + LEN > bufsize(BUF_ID).
  - Buffer sizes: 64 / 800 / 1632 / 768 / 32.
  - START while BUSY is ignored.
- FSM: IDLE -> SEL (write 0x08 = BUF_ID) -> IDX (write 0x18 = KIDX) -> then:
  - DIR=0: MRD (read word at ptr) -> KWR (write 0x10 with byte lane b in [7:0], b = 0..7, stop early when COUNT == LEN) -> MRD or FIN.
  - DIR=1: KRD (read 0x10, take k_rdata[7:0] into lane b) -> repeat until 8 bytes or COUNT == LEN -> MWR (m_be marks only filled lanes) -> KRD or FIN.
  - FIN: set DONE, clear BUSY -> IDLE.
- Memory pointer advances by 8 after each word. COUNT increments per KEM byte ack. LEN not a multiple of 8 gives a partial final word.
- Latency: first k_req is asserted the cycle after the START write is accepted.
- A CPU slave access in the same cycle as an internal ack is served normally; the slave path never stalls.

Optional Feature:
- Macro: MP64_KEM_DMA_AUTOCMD_EN.
- Defined:
  - CTRL[9:7] AUTOCMD, where 1/2/3 = keygen/encaps/decaps.
  - For DIR=0 only: after the last byte, enter CMD (write 0x00 = AUTOCMD), then POLL (read 0x00 until k_rdata[7:0] == 2), then FIN.
  - Poll timeout is 65535 reads; on expiry set ERR.
  - AUTOCMD values 0 or >3 skip CMD/POLL.
- Undefined: CTRL[9:7] read as 0 and are ignored; no CMD/POLL states.

Decomposition:
- mp64_pkg.vh gets:
  - KEM register offsets: CMD/STATUS 0x00, BUF_SEL 0x08, DATA 0x10, IDX 0x18.
  - KEM buffer IDs 0..4 and buffer sizes.
  - KEM status codes: idle 0, done 2.
  - DMA register offsets.
- One natural sub-module: mp64_kem_dma_pack. It is the 8-lane byte packer/unpacker holding the word register, lane counter and byte-enable generation.

Test Plan:
- mem->kem, BUF 0, KIDX 0, LEN 16, memory bytes i^0xAA -> 2 mem reads, 18 KEM writes (SEL, IDX, 16 DIN); KEM DOUT reads back 0xAA, 0xAB...; DONE=1, COUNT=16.
- kem->mem, BUF 4, LEN 13, KEM bytes 1..13 -> 2 mem writes; second write m_be=0x1F; memory holds 1..13; irq=1 with IRQ_EN.
- START with BUF_ID=5; separately LEN=0; separately BUF 4, KIDX 30, LEN 4 -> ERR=1 and zero k_req/m_req.
- rst asserted mid-KWR of a 64-byte transfer -> all outputs 0 same edge; BUSY=0; a new START runs cleanly.
- With MP64_KEM_DMA_AUTOCMD_EN: load 64-byte seed, AUTOCMD=1 -> CMD write 0x00=1, polls until status 2, DONE=1; PK[0] read via a DIR=1 transfer is nonzero.
- Slave: START while BUSY and a LEN write while BUSY -> both ignored; the LEN register keeps its old value.
